// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store-data path: access-size codes and helpers.
// Also used by the load-path extractor so both sides agree on size encoding.
package store_align_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_e;

    function automatic int size_bytes(input mem_size_e s);
        return 1 << int'(s);
    endfunction

endpackage

// File: rtl/store_align_buffer_if.sv
// Bundle of the store-request, memory-write and status signals of the store buffer.
// slave: the buffer itself; master: the pipeline/memory side driving it.
interface store_align_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_size;
    logic [DATA_W-1:0] st_data;
    logic              st_err;
    logic [ADDR_W-1:0] err_addr;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [NB-1:0]     mem_be;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ready,
        output st_ready, st_err, err_addr, mem_valid, mem_addr, mem_data, mem_be,
               count, empty
    );

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ready,
        input  st_ready, st_err, err_addr, mem_valid, mem_addr, mem_data, mem_be,
               count, empty
    );

endinterface

// File: rtl/store_align_buffer_lane_align.sv
// Combinational byte-lane steering: places the low n bytes of a store value into
// the lanes selected by address offset and size, and flags misaligned accesses.
module store_lane_align
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1,
    localparam int NB        = DATA_W / 8,
    localparam int OFF_W     = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [OFF_W-1:0]  off_i,
    input  mem_size_e         size_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [NB-1:0]     be_o,
    output logic              illegal_o
);

    int                nbytes;
    int                off;
    int                pos;
    logic [DATA_W-1:0] dmask;
    logic [NB-1:0]     bmask;

    // Both endiannesses reduce to a left shift of the low n bytes; only the
    // lowest destination lane (pos) differs.
    always_comb begin
        nbytes    = size_bytes(size_i);
        off       = int'(off_i) % NB;
        pos       = (BIG_ENDIAN != 0) ? (NB - off - nbytes) : off;
        dmask     = '1;
        bmask     = '1;
        data_o    = '0;
        be_o      = '0;
        illegal_o = 1'b1;
        if (nbytes <= NB && (off % nbytes) == 0) begin
            if (nbytes < NB) begin
                dmask = (DATA_W'(1) << (8 * nbytes)) - DATA_W'(1);
                bmask = (NB'(1) << nbytes) - NB'(1);
            end
            illegal_o = 1'b0;
            data_o    = (data_i & dmask) << (8 * pos);
            be_o      = bmask << pos;
        end
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns store data into byte lanes, rejects misaligned stores with an
// error pulse, and queues legal stores in a DEPTH-entry FIFO toward the memory port.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 4,
    parameter int BIG_ENDIAN = 1
) (
    input logic               clk,
    input logic               rst_n,
    store_align_buffer_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] al_data;
    logic [NB-1:0]     al_be;
    logic              al_illegal;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [NB-1:0]     be_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              st_ready, accept, push, pop;

    store_lane_align #(
        .DATA_W    (DATA_W),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .off_i    (bus.st_addr[OFF_W-1:0]),
        .size_i   (mem_size_e'(bus.st_size)),
        .data_i   (bus.st_data),
        .data_o   (al_data),
        .be_o     (al_be),
        .illegal_o(al_illegal)
    );

    // Readiness looks only at occupancy so mem_ready never reaches st_ready.
    assign st_ready = (count_q != CNT_W'(DEPTH));

    always_comb begin
        accept     = bus.st_valid && st_ready;
        push       = accept && !al_illegal;
        pop        = (count_q != '0) && bus.mem_ready;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        err_d      = accept && al_illegal;
        err_addr_d = err_d ? bus.st_addr : err_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            if (push) begin
                addr_q[wr_ptr_q] <= bus.st_addr & ~ADDR_W'(NB - 1);
                data_q[wr_ptr_q] <= al_data;
                be_q[wr_ptr_q]   <= al_be;
            end
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.st_err    = err_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.mem_valid = (count_q != '0);
    assign bus.mem_addr  = addr_q[rd_ptr_q];
    assign bus.mem_data  = data_q[rd_ptr_q];
    assign bus.mem_be    = be_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer (DATA_W=32, DEPTH=4, big-endian): scenario tasks plus a
// scoreboard that compares every drained entry against a byte-wise reference model.
module tb_store_align_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    store_align_buffer_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) bus ();

    store_align_buffer #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (4),
        .BIG_ENDIAN(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian reference: source byte k (k=0 most significant of n) -> lane 3-(off+k).
    function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz,
                                   input logic [31:0] d);
        exp_t m;
        int   n;
        int   off;
        int   lane;
        n      = 1 << sz;
        off    = int'(a[1:0]);
        m.addr = {a[31:2], 2'b00};
        m.data = '0;
        m.be   = '0;
        for (int k = 0; k < n; k++) begin
            lane = 3 - (off + k);
            m.data[8*lane +: 8] = d[8*(n-1-k) +: 8];
            m.be[lane] = 1'b1;
        end
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push_store(input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] d, input bit legal);
        int guard;
        guard        = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_size  = sz;
        bus.st_data  = d;
        @(negedge clk);
        while (!bus.st_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout addr=%h st_ready stayed 0", a);
        end else if (legal) begin
            exp_q.push_back(model(a, sz, d));
        end
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
    endtask

    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_valid && bus.mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got addr=%h data=%h be=%b expected nothing",
                             bus.mem_addr, bus.mem_data, bus.mem_be);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_data, bus.mem_be} !== e) begin
                        errors++;
                        $display("FAIL sb_entry got addr=%h data=%h be=%b expected addr=%h data=%h be=%b",
                                 bus.mem_addr, bus.mem_data, bus.mem_be, e.addr, e.data, e.be);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard         = 0;
        bus.mem_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.mem_valid) && guard < 200) begin
            guard++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (guard >= 200 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL drain count=%0d empty=%b pending=%0d expected 0/1/0",
                     bus.count, bus.empty, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.mem_valid, bus.count, bus.st_err, bus.st_ready, bus.empty} !== 7'b0_000_0_1_1) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b count=%0d err=%b ready=%b empty=%b expected 0 0 0 1 1",
                     bus.mem_valid, bus.count, bus.st_err, bus.st_ready, bus.empty);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.mem_addr, bus.mem_data, bus.mem_be, bus.err_addr} !== '0 || bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got addr=%h data=%h be=%b err_addr=%h valid=%b expected zeros",
                     bus.mem_addr, bus.mem_data, bus.mem_be, bus.err_addr, bus.mem_valid);
        end
    endtask

    task automatic test_align();
        logic [31:0] addrs [4] = '{32'h103, 32'h100, 32'h202, 32'h300};
        logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic [31:0] datas [4] = '{32'hAB, 32'hAB, 32'h1234, 32'hDEADBEEF};
        logic [31:0] exp_a [4] = '{32'h100, 32'h100, 32'h200, 32'h300};
        logic [31:0] exp_d [4] = '{32'h000000AB, 32'hAB000000, 32'h00001234, 32'hDEADBEEF};
        logic [3:0]  exp_b [4] = '{4'b0001, 4'b1000, 4'b0011, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b0;
            push_store(addrs[i], sizes[i], datas[i], 1'b1);
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp_a[i] || bus.mem_data !== exp_d[i] ||
                bus.mem_be !== exp_b[i] || bus.count !== 3'd1) begin
                errors++;
                $display("FAIL align_%0d got valid=%b addr=%h data=%h be=%b count=%0d expected 1 %h %h %b 1",
                         i, bus.mem_valid, bus.mem_addr, bus.mem_data, bus.mem_be, bus.count,
                         exp_a[i], exp_d[i], exp_b[i]);
            end
            wait_drain();
        end
    endtask

    task automatic test_illegal();
        bus.mem_ready = 1'b1;
        push_store(32'h201, 2'd1, 32'h5555, 1'b0);
        checks++;
        if (bus.st_err !== 1'b1 || bus.err_addr !== 32'h201 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL illegal_half got err=%b err_addr=%h count=%0d expected 1 201 0",
                     bus.st_err, bus.err_addr, bus.count);
        end
        push_store(32'h302, 2'd2, 32'h6666, 1'b0);
        checks++;
        if (bus.st_err !== 1'b1 || bus.err_addr !== 32'h302 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL illegal_word got err=%b err_addr=%h count=%0d expected 1 302 0",
                     bus.st_err, bus.err_addr, bus.count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.st_err !== 1'b0 || bus.mem_valid !== 1'b0 || bus.err_addr !== 32'h302) begin
            errors++;
            $display("FAIL illegal_pulse got err=%b valid=%b err_addr=%h expected 0 0 302",
                     bus.st_err, bus.mem_valid, bus.err_addr);
        end
        push_store(32'h400, 2'd3, 32'h7777, 1'b0);
        checks++;
        if (bus.st_err !== 1'b1 || bus.err_addr !== 32'h400 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL illegal_dword got err=%b err_addr=%h count=%0d expected 1 400 0",
                     bus.st_err, bus.err_addr, bus.count);
        end
    endtask

    task automatic test_full_stall();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_store(32'h1000 + 32'(4 * i), 2'd2, 32'hA0000000 + 32'(i), 1'b1);
        checks++;
        if (bus.count !== 3'd4 || bus.st_ready !== 1'b0 || bus.mem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL full got count=%0d ready=%b head=%h expected 4 0 1000",
                     bus.count, bus.st_ready, bus.mem_addr);
        end
        fork
            push_store(32'h1010, 2'd2, 32'hA0000004, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (bus.count !== 3'd4 || bus.mem_addr !== 32'h1000 || bus.mem_data !== 32'hA0000000) begin
                    errors++;
                    $display("FAIL stall_hold got count=%0d head=%h data=%h expected 4 1000 a0000000",
                             bus.count, bus.mem_addr, bus.mem_data);
                end
                bus.mem_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        bus.mem_ready = 1'b0;
        push_store(32'h2000, 2'd2, 32'h11111111, 1'b1);
        push_store(32'h2004, 2'd2, 32'h22222222, 1'b1);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = (32'h3000 + 32'($urandom_range(0, 255))) & ~((32'd1 << sz) - 32'd1);
            push_store(a, sz, $urandom, 1'b1);
            checks++;
            if (bus.count !== 3'd2) begin
                errors++;
                $display("FAIL stream_count_%0d got %0d expected 2", i, bus.count);
            end
        end
        wait_drain();
    endtask

    task automatic test_async_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_store(32'h5000 + 32'(4 * i), 2'd2, 32'hC0DE0000 + 32'(i), 1'b1);
        push_store(32'h5001, 2'd2, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.count !== 3'd0 || bus.st_err !== 1'b0 || bus.err_addr !== '0) begin
            errors++;
            $display("FAIL async_reset got valid=%b count=%0d err=%b err_addr=%h expected 0 0 0 0",
                     bus.mem_valid, bus.count, bus.st_err, bus.err_addr);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_store(32'h6003, 2'd0, 32'h5A, 1'b1);
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h6000 || bus.mem_data !== 32'h0000005A ||
            bus.mem_be !== 4'b0001 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL post_reset got valid=%b addr=%h data=%h be=%b count=%0d expected 1 6000 5a 0001 1",
                     bus.mem_valid, bus.mem_addr, bus.mem_data, bus.mem_be, bus.count);
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_size   = '0;
        bus.st_data   = '0;
        bus.mem_ready = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_align();
        test_illegal();
        test_full_stall();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Parametrised store-data path between the pipeline's memory stage and the data memory/cache write port.
- Aligns store data into the correct byte lanes from address offset and access size, and generates per-byte write enables.
- Rejects misaligned stores with an error pulse.
- Queues accepted stores in a DEPTH-entry FIFO drained over a valid/ready handshake, decoupling the pipeline from memory write stalls.

Parameters:
DATA_W, 32, memory word width in bits; a multiple of 8, power-of-two bytes (NB = DATA_W/8).
ADDR_W, 32, byte-address width.
DEPTH, 4, FIFO entries; power of two, at least 2.
BIG_ENDIAN, 1, 1: byte offset 0 maps to lane NB-1 (bits [DATA_W-1:DATA_W-8]); 0: offset 0 maps to lane 0.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept; equals (count != DEPTH)
st_addr  in  ADDR_W  byte address
st_size  in  2  log2 of access bytes: 0 byte, 1 half, 2 word, 3 dword
st_data  in  DATA_W  store value, right-justified in the low bits
st_err  out  1  one-cycle pulse: previous accepted request was misaligned/illegal
err_addr  out  ADDR_W  address of the most recent rejected store
mem_valid  out  1  head entry valid
mem_ready  in  1  memory accepts head entry
mem_addr  out  ADDR_W  word-aligned address (low log2(NB) bits zero)
mem_data  out  DATA_W  lane-aligned data; unused lanes zero
mem_be  out  NB  byte enables, bit i enables lane i
count  out  log2(DEPTH)+1  current occupancy
empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low): FIFO pointers and count = 0; mem_valid = 0; mem_addr, mem_data, mem_be = 0; st_err = 0; err_addr = 0. A reset mid-operation discards all queued stores.
- Acceptance: a request is taken on a rising edge with st_valid && st_ready. st_ready depends only on count, with no combinational path from mem_ready. A full buffer stalls even when a pop occurs the same cycle.
- Legality: the access is legal when 2^st_size <= NB and st_addr[st_size-1:0] == 0.
  - Illegal accepted request: not enqueued; st_err = 1 in the following cycle only; err_addr captured the same edge.
  - Back-to-back illegal requests give st_err high for consecutive cycles, and err_addr updates each time.
- Alignment of a legal request, with off = st_addr[log2(NB)-1:0] and n = 2^st_size bytes:
  - Take the low n bytes of st_data.
  - BIG_ENDIAN = 1: source byte k (k = 0 is most significant of the n) goes to lane NB-1-(off+k); be sets lanes NB-1-off down to NB-off-n.
  - BIG_ENDIAN = 0: source byte k (k = 0 least significant) goes to lane off+k.
  - Lanes not enabled carry 0.
- Enqueue latency: an entry accepted at edge T is presented (mem_valid = 1) after edge T, i.e. the next cycle. FIFO outputs are driven directly from registered storage.
- Dequeue: on an edge with mem_valid && mem_ready, the head is removed. While mem_valid && !mem_ready, mem_addr/mem_data/mem_be stay stable. mem_valid never drops without a handshake, except on reset.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count unchanged, and order is preserved.
- Empty with enqueue: mem_valid rises the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- When empty, mem_addr/mem_data/mem_be hold their last values (don't-care); they must not be X after reset.

Decomposition:
- Shared header MemSize.vh: size codes SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2, SZ_DWORD=2'd3. Pipeline decode maps SB/SH/SW opcodes onto these.
- Sub-module store_lane_align: purely combinational. Inputs st_addr offset, st_size, st_data; outputs aligned data, be, and illegal flag. Parameters DATA_W, BIG_ENDIAN. Reused by the load-path extractor.
- The top level holds FIFO storage, pointers, count, and the error register.

Test Plan:
- Reset then BIG_ENDIAN=1, DATA_W=32: SB addr 0x103 data 0xAB -> next cycle mem_addr 0x100, mem_data 0x000000AB, mem_be 4'b0001; SB addr 0x100 -> 0xAB000000, be 4'b1000.
- SH addr 0x202 data 0x1234 -> mem_data 0x00001234, be 4'b0011; SW addr 0x300 data 0xDEADBEEF -> be 4'b1111, data unchanged.
- SH addr 0x201 and SW addr 0x302 -> not enqueued; st_err pulses one cycle each; err_addr 0x201 then 0x302; count stays 0.
- mem_ready held 0, push 5 stores with DEPTH=4 -> st_ready low after 4th, count=4, head stable. Raise mem_ready -> drained in push order, 5th accepted only once count<4.
- Continuous push and pop at count=2 for 10 cycles -> count stays 2 and output order matches input order across pointer wrap.
- Assert rst_n low with 3 entries queued and mem_valid high -> mem_valid, count, st_err go 0 immediately (asynchronously); after release the first new store appears one cycle after acceptance.
